binoc_router_xy: RTL
====================

Name: binoc_router_xy

Overview:
- Parametrised next-generation BiNoC mesh router: five ports (east, north, west, south, local), each with a per-input flit FIFO.
- Deterministic XY routing; per-output round-robin arbitration; registered output stage.
- Replaces the fixed 32-bit, unbuffered-depth base router.
- Instantiated once per mesh node; neighbours connect through req/gnt/full handshakes.

Parameters:
- X, 0, router column coordinate
- Y, 0, router row coordinate
- DATA_W, 32, flit width in bits
- COORD_W, 4, width of each destination coordinate field in the header
- DEPTH, 4, per-input FIFO depth in flits (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_up  in  5  upstream request per input port; index 0=E, 1=N, 2=W, 3=S, 4=L
- pkt_in  in  5*DATA_W  input flits; slice i = [i*DATA_W +: DATA_W]
- up_full  out  5  input FIFO i full
- gnt_up  out  5  input i accepted flit this cycle
- req_dn  out  5  output register i holds a valid flit
- pkt_out  out  5*DATA_W  output flits, same slicing as pkt_in
- dn_full  in  5  downstream buffer on output i full
- gnt_dn  in  5  downstream on output i grants

Behaviour:
- Reset is asynchronous, active-high, and also applies mid-operation. It clears:
  - all FIFOs to empty;
  - all output registers to invalid;
  - pkt_out to 0;
  - req_dn, gnt_up and up_full to 0;
  - round-robin pointers to 0.
  In-flight flits are discarded.
- Flits are single-flit packets. Header fields:
  - dst_x = flit[DATA_W-1 -: COORD_W]
  - dst_y = flit[DATA_W-1-COORD_W -: COORD_W]
  - Both compared unsigned.
- Input side:
  - Write condition: req_up[i] && !up_full[i] at the rising edge.
  - gnt_up[i] = req_up[i] && !up_full[i], combinational.
  - up_full[i] is high when count == DEPTH.
  - A write attempted while full is ignored, even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves count unchanged.
- Routing on the FIFO head flit:
  - dst_x > X → E
  - dst_x < X → W
  - otherwise dst_y > Y → N
  - otherwise dst_y < Y → S
  - otherwise → L
  - Routing is computed whatever the arrival port; no U-turn filtering.
- Output stage, per output o:
  - Drain: a transfer occurs when req_dn[o] && gnt_dn[o] && !dn_full[o] at the edge.
  - Load: if the register is invalid, or draining this cycle, the arbiter picks one input whose non-empty head routes to o. It pops that FIFO and loads the flit into the register, with req_dn[o] high the following cycle.
  - A drained output reloads in the same edge, so back-to-back throughput is 1 flit/cycle per output.
  - pkt_out holds stable while req_dn is high and no transfer occurs.
- Arbitration:
  - Round-robin per output.
  - Search order starts at ptr[o] and wraps 4→0.
  - After a grant to input i, ptr[o] = (i+1) mod 5.
  - An input head can be granted by exactly one output (its routed output); no conflict among outputs.
- Latency: flit accepted at edge N appears at the FIFO head after N; it is loaded to the output register at edge N+1; req_dn is high in cycle N+1. Minimum 2 edges from request to output valid.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: BINOC_ROUTER_STATS_EN.
- When defined:
  - Extra output port stat_flits, out, 5*16: per-output count of completed downstream transfers.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Extra output port stat_drop, out, 5: sticky flag per input, set when req_up[i] is high while up_full[i] is high; cleared only by rst.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- X=1, Y=1, COORD_W=4. W input sends 32'h2100_0001, all gnt_dn=1, dn_full=0 → gnt_up[2]=1 that cycle; req_dn[0]=1 with pkt_out[E]=32'h2100_0001 two edges later; one-cycle pulse.
- Routing sweep from L input:
  - 32'h0100_0002 → W
  - 32'h1200_0003 → N
  - 32'h1000_0004 → S
  - 32'h1100_0005 → L
  - Each appears only on its routed output.
- E, N and W all send flits for L on the same cycle, held for 3 cycles, ptr=0 → L output order is E, N, W. A fourth round led by N yields W then E according to the pointer.
- Backpressure: dn_full[0]=1, W sends 5 flits to E with DEPTH=4 → 1 flit held in the output register and 4 in the FIFO; up_full[2]=1 and the 6th request gets gnt_up=0. Release dn_full → 5 flits are delivered in order, 1 per cycle.
- Assert rst mid-stream with 3 flits buffered → req_dn, up_full and pkt_out go to 0 immediately (async); after release no stale flit emerges.
- With BINOC_ROUTER_STATS_EN defined, 3 flits through E → stat_flits[E]=3; the write-while-full case sets stat_drop[2]=1.

Source files
------------

// File: rtl/binoc_router_xy.sv
// binoc_router_xy: 5-port XY mesh router, per-input FIFOs, round-robin output stage.
// Define BINOC_ROUTER_STATS_EN to add the stat_flits / stat_drop ports.
module binoc_router_xy #(
  parameter int X       = 0,
  parameter int Y       = 0,
  parameter int DATA_W  = 32,
  parameter int COORD_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          req_up,
  input  logic [5*DATA_W-1:0] pkt_in,
  output logic [4:0]          up_full,
  output logic [4:0]          gnt_up,
  output logic [4:0]          req_dn,
  output logic [5*DATA_W-1:0] pkt_out,
`ifdef BINOC_ROUTER_STATS_EN
  output logic [5*16-1:0]     stat_flits,
  output logic [4:0]          stat_drop,
`endif
  input  logic [4:0]          dn_full,
  input  logic [4:0]          gnt_dn
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [COORD_W-1:0] XC = COORD_W'(X);
  localparam logic [COORD_W-1:0] YC = COORD_W'(Y);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [5][DEPTH];
  logic [AW-1:0]     wp_q [5];
  logic [AW-1:0]     rp_q [5];
  logic [AW:0]       cnt_q [5];
  logic [DATA_W-1:0] head [5];
  logic [4:0]        route [5];
  logic [4:0]        push, pop, nemp;

  logic [4:0]        vld_q;
  logic [DATA_W-1:0] obuf_q [5];
  logic [2:0]        ptr_q [5];
  logic [2:0]        ptr_d [5];
  logic [2:0]        sel [5];
  logic [4:0]        drain, load;

  // Head decode: one-hot routed output per input FIFO
  always_comb begin
    logic [COORD_W-1:0] dx, dy;
    for (int i = 0; i < 5; i++) begin
      head[i]    = mem_q[i][rp_q[i]];
      nemp[i]    = cnt_q[i] != '0;
      up_full[i] = cnt_q[i] == FULLC;
      dx = head[i][DATA_W-1 -: COORD_W];
      dy = head[i][DATA_W-1-COORD_W -: COORD_W];
      route[i] = '0;
      priority case (1'b1)
        dx > XC: route[i][0] = 1'b1;
        dx < XC: route[i][2] = 1'b1;
        dy > YC: route[i][1] = 1'b1;
        dy < YC: route[i][3] = 1'b1;
        default: route[i][4] = 1'b1;
      endcase
    end
  end

  assign push   = req_up & ~up_full;
  assign gnt_up = push & {5{~rst}};

  // Each head routes to one output only, so per-output pops never collide
  always_comb begin
    int idx;
    idx   = 0;
    drain = vld_q & gnt_dn & ~dn_full;
    pop   = '0;
    load  = '0;
    for (int o = 0; o < 5; o++) begin
      ptr_d[o] = ptr_q[o];
      sel[o]   = '0;
      if (!vld_q[o] || drain[o]) begin
        for (int k = 0; k < 5; k++) begin
          idx = (int'(ptr_q[o]) + k) % 5;
          if (!load[o] && nemp[idx] && route[idx][o]) begin
            load[o]  = 1'b1;
            sel[o]   = 3'(idx);
            pop[idx] = 1'b1;
            ptr_d[o] = (idx == 4) ? 3'd0 : 3'(idx + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (push[i]) mem_q[i][wp_q[i]] <= pkt_in[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (push[i]) wp_q[i] <= wp_q[i] + 1'b1;
        if (pop[i])  rp_q[i] <= rp_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int o = 0; o < 5; o++) begin
        obuf_q[o] <= '0;
        ptr_q[o]  <= '0;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        ptr_q[o] <= ptr_d[o];
        if (load[o]) begin
          vld_q[o]  <= 1'b1;
          obuf_q[o] <= head[sel[o]];
        end else if (drain[o]) begin
          vld_q[o] <= 1'b0;
        end
      end
    end
  end

  assign req_dn = vld_q;

  always_comb begin
    pkt_out = '0;
    for (int o = 0; o < 5; o++)
      pkt_out[o*DATA_W +: DATA_W] = obuf_q[o];
  end

`ifdef BINOC_ROUTER_STATS_EN
  logic [15:0] sf_q [5];
  logic [4:0]  sd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_q <= '0;
      for (int o = 0; o < 5; o++) sf_q[o] <= '0;
    end else begin
      sd_q <= sd_q | (req_up & up_full);
      for (int o = 0; o < 5; o++)
        if (drain[o] && sf_q[o] != 16'hFFFF) sf_q[o] <= sf_q[o] + 16'd1;
    end
  end

  always_comb begin
    stat_flits = '0;
    for (int o = 0; o < 5; o++) stat_flits[o*16 +: 16] = sf_q[o];
  end

  assign stat_drop = sd_q;
`endif

endmodule
